// File: rtl/cpu_sequencer.sv
// cpu_sequencer: sequential front end of the 8-phase accumulator CPU.
// Owns the phase counter, instruction register, program counter, halt
// latch and the retired-instruction counter.
// Optional single-instruction stepping is compiled in with the macro
// CPU_SEQUENCER_STEP_EN, which adds the step_mode and step inputs.
//
// Strobe semantics: ld_ir/inc_pc/ld_pc are level strobes that act only on
// an edge where the sequencer advances a phase; resume and step are
// single-cycle pulses sampled on the rising edge; no handshaking back.
module cpu_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int ADDR_WIDTH   = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    ld_ir,
    input  logic                    inc_pc,
    input  logic                    ld_pc,
    input  logic                    halt,
    input  logic                    sel,
    input  logic                    resume,
`ifdef CPU_SEQUENCER_STEP_EN
    input  logic                    step_mode,
    input  logic                    step,
`endif
    output logic [2:0]              phase,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0]   ir_addr,
    output logic [ADDR_WIDTH-1:0]   pc_addr,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic                    halted,
    output logic [CNT_WIDTH-1:0]    instr_cnt
);

    // Sequencer mode; MODE_HALTED is visible directly as the halted output.
    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_HALTED    = 2'd1,
        MODE_STEP_WAIT = 2'd2
    } mode_t;

    mode_t                  mode_q, mode_d;
    logic                   advance;   // this edge executes a normal phase
    logic                   wrap;      // this edge is a phase 7 -> 0 transition
    logic                   step_on;
    logic [2:0]             phase_q;
    logic [DATA_WIDTH-1:0]  ir_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [CNT_WIDTH-1:0]   cnt_q;

`ifdef CPU_SEQUENCER_STEP_EN
    assign step_on = step_mode;
`else
    assign step_on = 1'b0;
`endif

    assign wrap = advance && (phase_q == 3'd7);

    // Mode next-state: decides whether this edge advances and where it lands.
    always_comb begin
        mode_d  = mode_q;
        advance = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                if (halt) mode_d = MODE_HALTED;
                else      advance = 1'b1;
            end
            MODE_HALTED: begin
                // halt is ignored on the resume edge so the HLT's own PC
                // increment completes without re-entering the halt.
                if (resume) begin
                    mode_d  = MODE_RUN;
                    advance = 1'b1;
                end
            end
`ifdef CPU_SEQUENCER_STEP_EN
            MODE_STEP_WAIT: begin
                if (halt) begin
                    mode_d = MODE_HALTED;
                end else if (!step_mode || step) begin
                    mode_d  = MODE_RUN;
                    advance = 1'b1;
                end
            end
`endif
            default: mode_d = MODE_RUN;
        endcase
        // Each completed instruction parks in step-wait while stepping.
        if (wrap && step_on) mode_d = MODE_STEP_WAIT;
    end

    // State register plus datapath updates, gated by advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_RUN;
            phase_q <= 3'd0;
            ir_q    <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            mode_q <= mode_d;
            if (advance) begin
                phase_q <= phase_q + 3'd1;
                if (ld_ir) ir_q <= data_in;
                if (ld_pc)       pc_q <= ir_q[ADDR_WIDTH-1:0];
                else if (inc_pc) pc_q <= pc_q + ADDR_WIDTH'(1);
                if (wrap && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign phase     = phase_q;
    assign opcode    = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign ir_addr   = ir_q[ADDR_WIDTH-1:0];
    assign pc_addr   = pc_q;
    assign addr      = sel ? pc_q : ir_q[ADDR_WIDTH-1:0];
    assign halted    = (mode_q == MODE_HALTED);
    assign instr_cnt = cnt_q;

endmodule
